// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the parallel-to-serial output stage.
package byte_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/byte_serializer.sv
// Parallel-to-serial output stage: takes one word over valid/ready and shifts it
// out one bit per accepted serial beat, flagging the final bit of each word.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic out_bit;
  logic last_bit;

  // Bit at the output end of the shift register and final-bit decode.
  always_comb begin
    out_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    last_bit = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: capture in IDLE, shift toward the output end on each beat.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          if (last_bit) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no input-to-output paths.
  assign in_ready  = (state_q == ST_IDLE);
  assign ser_valid = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_SHIFT);
  assign ser_data  = (state_q == ST_SHIFT) && out_bit;
  assign ser_last  = (state_q == ST_SHIFT) && last_bit;

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboard bench for byte_serializer: one LSB-first and one MSB-first instance,
// expected bit streams derived from each accepted word and popped per serial beat.
module tb_byte_serializer;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic d;
    logic l;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_v        [2];
  logic         in_valid_v  [2];
  logic         in_ready_v  [2];
  logic         ser_data_v  [2];
  logic         ser_valid_v [2];
  logic         ser_ready_v [2];
  logic         ser_last_v  [2];
  logic         busy_v      [2];

  beat_t        q0[$];
  beat_t        q1[$];
  int           n_cmp;
  int           n_err;
  int           cyc;
  int           ph;
  int           rdy_mode [2];
  logic [W-1:0] obs_word [2];
  int           last_obs [2];
  int           last_exp [2];

  byte_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in(in_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .ser_data(ser_data_v[0]), .ser_valid(ser_valid_v[0]),
    .ser_ready(ser_ready_v[0]), .ser_last(ser_last_v[0]), .busy(busy_v[0])
  );

  byte_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in(in_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .ser_data(ser_data_v[1]), .ser_valid(ser_valid_v[1]),
    .ser_ready(ser_ready_v[1]), .ser_last(ser_last_v[1]), .busy(busy_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qs(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model: word -> ordered list of (bit, last) the sink must see.
  task automatic push_word(input int i, input logic [W-1:0] w);
    beat_t e;
    for (int k = 0; k < int'(W); k++) begin
      e.d = (i == 0) ? w[k] : w[W-1-k];
      e.l = (k == int'(W) - 1);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    last_exp[i]++;
  endtask

  // Serial sink readiness: 0 always ready, 1 random, 2 pattern 1,0,0.
  initial begin
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      for (int i = 0; i < 2; i++) begin
        case (rdy_mode[i])
          0:       ser_ready_v[i] = 1'b1;
          1:       ser_ready_v[i] = 1'($urandom_range(0, 1));
          default: ser_ready_v[i] = ((ph % 3) == 1);
        endcase
      end
    end
  end

  task automatic mon(input int i);
    beat_t e;
    chk("in_ready_vs_ser_valid", 32'(in_ready_v[i]), 32'(!ser_valid_v[i]));
    chk("busy_vs_ser_valid", 32'(busy_v[i]), 32'(ser_valid_v[i]));
    if (ser_valid_v[i] && ser_ready_v[i]) begin
      if (qs(i) == 0) begin
        chk("beat_without_word", 32'(ser_valid_v[i]), 32'(0));
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk("ser_data", 32'(ser_data_v[i]), 32'(e.d));
        chk("ser_last", 32'(ser_last_v[i]), 32'(e.l));
        obs_word[i] = {obs_word[i][W-2:0], ser_data_v[i]};
        if (ser_last_v[i]) last_obs[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  // Producer: in/in_valid already driven; wait for acceptance, log the edge.
  task automatic accept(input int i, input bit hold, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_v[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(in_ready_v[i]), 32'(1));
    push_word(i, in_v[i]);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) in_valid_v[i] = 1'b0;
    @(negedge clk);
    chk("first_bit_valid", 32'(ser_valid_v[i]), 32'(1));
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((qs(i) != 0 || !in_ready_v[i]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(qs(i)), 32'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_words(input int i);
    int t;
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      tick();
      in_v[i]       = W'($urandom);
      in_valid_v[i] = 1'b1;
      accept(i, 1'b0, t);
      in_v[i] = W'($urandom);
    end
  endtask

  initial begin
    int t1;
    int t2;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_v[i]        = '0;
      in_valid_v[i]  = 1'b0;
      ser_ready_v[i] = 1'b0;
      rdy_mode[i]    = 0;
      obs_word[i]    = '0;
      last_obs[i]    = 0;
      last_exp[i]    = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(in_ready_v[i]), 32'(1));
      chk("rst_ser_valid", 32'(ser_valid_v[i]), 32'(0));
      chk("rst_ser_data", 32'(ser_data_v[i]), 32'(0));
      chk("rst_ser_last", 32'(ser_last_v[i]), 32'(0));
      chk("rst_busy", 32'(busy_v[i]), 32'(0));
    end
    #2 rst_n = 1'b1;

    // A5 LSB-first, sink always ready.
    tick();
    in_v[0] = 8'hA5; in_valid_v[0] = 1'b1;
    accept(0, 1'b0, t1);
    wait_idle(0);
    chk("a5_lsb_stream", 32'(obs_word[0]), 32'(8'b1010_0101));

    // 81 MSB-first.
    tick();
    in_v[1] = 8'h81; in_valid_v[1] = 1'b1;
    accept(1, 1'b0, t1);
    wait_idle(1);
    chk("81_msb_stream", 32'(obs_word[1]), 32'(8'b1000_0001));

    // 3C with stalling sink.
    rdy_mode[0] = 2;
    tick();
    in_v[0] = 8'h3C; in_valid_v[0] = 1'b1;
    accept(0, 1'b0, t1);
    wait_idle(0);
    chk("3c_stall_stream", 32'(obs_word[0]), 32'(8'b0011_1100));
    rdy_mode[0] = 0;

    // in_valid held, in changed to FF mid-word: FF follows after one bubble.
    tick();
    in_v[0] = 8'h5C; in_valid_v[0] = 1'b1;
    accept(0, 1'b1, t1);
    in_v[0] = 8'hFF;
    accept(0, 1'b0, t2);
    chk("hold_bubble_interval", 32'(t2 - t1), 32'(W + 1));
    wait_idle(0);
    chk("ff_stream", 32'(obs_word[0]), 32'(8'hFF));

    // Back-to-back 01, 80 on the MSB-first instance.
    tick();
    in_v[1] = 8'h01; in_valid_v[1] = 1'b1;
    accept(1, 1'b1, t1);
    in_v[1] = 8'h80;
    accept(1, 1'b0, t2);
    chk("b2b_interval", 32'(t2 - t1), 32'(W + 1));
    wait_idle(1);
    chk("80_msb_stream", 32'(obs_word[1]), 32'(8'h80));

    // Reset mid-word: outputs drop immediately, word discarded.
    tick();
    in_v[0] = 8'h5A; in_valid_v[0] = 1'b1;
    accept(0, 1'b0, t1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ser_valid", 32'(ser_valid_v[0]), 32'(0));
    chk("midrst_in_ready", 32'(in_ready_v[0]), 32'(1));
    chk("midrst_busy", 32'(busy_v[0]), 32'(0));
    chk("midrst_ser_last", 32'(ser_last_v[0]), 32'(0));
    chk("midrst_ser_data", 32'(ser_data_v[0]), 32'(0));
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      last_obs[i] = 0;
      last_exp[i] = 0;
    end
    @(posedge clk);
    #3 rst_n = 1'b1;

    tick();
    in_v[0] = 8'h96; in_valid_v[0] = 1'b1;
    accept(0, 1'b0, t1);
    wait_idle(0);
    chk("post_rst_96_stream", 32'(obs_word[0]), 32'(8'b0110_1001));

    // Random words against random sink readiness on both instances.
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    fork
      rand_words(0);
      rand_words(1);
    join
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    wait_idle(0);
    wait_idle(1);
    chk("last_pulses_lsb", 32'(last_obs[0]), 32'(last_exp[0]));
    chk("last_pulses_msb", 32'(last_obs[1]), 32'(last_exp[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
